uart_rx_frame: RTL and testbench

- Host-side receiver for the measurement-result UART stream.
- Deserialises 8N1 bytes, hunts for the frame header and assembles four 32-bit counters: cnt_clk, cnt_square, cnt_pulse, cnt_time.
- Verifies the checksum, then presents the counters with a one-cycle valid strobe.
- Used in loopback benches and in a companion display/logging board that decodes the measurement link.

---
 rtl/uart_frame_pkg.sv | 26 ++
 rtl/uart_rx_byte.sv | 126 ++++++++++++
 rtl/uart_rx_frame.sv | 124 ++++++++++++
 tb/tb_uart_rx_frame.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared definitions for the measurement-link UART receiver.
//   HEADER_DEFAULT : frame start byte
//   FRAME_LEN      : bytes per frame (header + 16 payload + checksum)
//   PAYLOAD_LEN    : counter bytes between header and checksum
//   parse_state_t  : frame parser states
//   rx_state_t     : byte receiver states
package uart_frame_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam int         FRAME_LEN      = 18;
  localparam int         PAYLOAD_LEN    = 16;

  typedef enum logic [1:0] {
    HUNT,
    PAYLOAD,
    CHECK
  } parse_state_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   rx          : UART line, idle high, asynchronous to clk
//   data        : received byte, valid while byte_valid is high
//   byte_valid  : one-cycle strobe, a byte with a good stop bit arrived
//   byte_err    : one-cycle strobe, stop bit sampled low
module uart_rx_byte
  import uart_frame_pkg::*;
#(
  parameter int BAUD_DIV = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       byte_err
);

  localparam int              DIV_W    = $clog2(BAUD_DIV);
  localparam logic [DIV_W-1:0] DIV_FULL = DIV_W'(BAUD_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BAUD_DIV / 2 - 1);

  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  rx_state_t        state;
  logic [DIV_W-1:0] div;
  logic [2:0]       bit_cnt;
  logic             stop_wait;
  logic [7:0]       shreg;
  logic             tick;

  assign tick = (div == '0);
  // The shift register is stable from the last data bit until the next
  // byte's first data bit, so it can be presented directly.
  assign data = shreg;

  // Synchroniser and edge history preset to the idle level so that reset
  // release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each stage take the previous
      // stage's old value, which is what builds a real flop chain.
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      div        <= '0;
      bit_cnt    <= '0;
      stop_wait  <= 1'b0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rx_prev && !rx_sync) begin
            state <= START;
            div   <= DIV_HALF;
          end
        end
        START: begin
          // Mid start bit: still low means a real start, high means a glitch.
          if (tick) begin
            if (!rx_sync) begin
              state   <= DATA;
              div     <= DIV_FULL;
              bit_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            div <= div - 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            div     <= DIV_FULL;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            div <= div - 1'b1;
          end
        end
        STOP: begin
          if (stop_wait) begin
            // Break or framing error: only re-arm once the line is idle again.
            if (rx_sync) begin
              stop_wait <= 1'b0;
              state     <= IDLE;
            end
          end else if (tick) begin
            if (rx_sync) begin
              byte_valid <= 1'b1;
              state      <= IDLE;
            end else begin
              byte_err  <= 1'b1;
              stop_wait <= 1'b1;
            end
          end else begin
            div <= div - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: pure datapath register, always fully overwritten before it is
  // qualified by byte_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == DATA && tick) shreg <= {rx_sync, shreg[7:1]};
  end

endmodule

// File: rtl/uart_rx_frame.sv
// Measurement-link frame receiver: header hunt, counter assembly,
// checksum verification and inter-byte timeout.
//   clk, rst_n   : system clock, asynchronous active-low reset
//   rx           : UART line, idle high
//   cnt_clk, cnt_square, cnt_pulse, cnt_time : counters of the last good frame
//   frame_valid  : one-cycle strobe, all counters updated this cycle
//   chk_err      : one-cycle strobe, checksum mismatch, frame dropped
//   frm_err      : one-cycle strobe, stop bit low or inter-byte timeout
module uart_rx_frame
  import uart_frame_pkg::*;
#(
  parameter int         CLK_FREQ     = 100_000_000,
  parameter int         BAUD         = 115200,
  parameter logic [7:0] HEADER       = HEADER_DEFAULT,
  parameter int         TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [31:0] cnt_clk,
  output logic [31:0] cnt_square,
  output logic [31:0] cnt_pulse,
  output logic [31:0] cnt_time,
  output logic        frame_valid,
  output logic        chk_err,
  output logic        frm_err
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int TO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  logic [7:0]      data;
  logic            byte_valid;
  logic            byte_err;
  parse_state_t    state;
  logic [3:0]      idx;
  logic [7:0]      sum;
  logic [127:0]    shadow;
  logic [TO_W-1:0] to_cnt;
  logic            timeout;

  uart_rx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data       (data),
    .byte_valid (byte_valid),
    .byte_err   (byte_err)
  );

  // to_cnt holds the number of cycles elapsed since the last byte_valid, so
  // frm_err lands exactly TO_LIMIT cycles after the last byte of a stalled frame.
  assign timeout = (state != HUNT) && (to_cnt == TO_W'(TO_LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     to_cnt <= '0;
    else if (byte_valid)            to_cnt <= TO_W'(1);
    else if (state == HUNT || timeout) to_cnt <= '0;
    else                            to_cnt <= to_cnt + 1'b1;
  end

  // Counter bytes arrive MSB first, so shifting left leaves cnt_clk on top.
  always_ff @(posedge clk) begin
    if (state == PAYLOAD && byte_valid) shadow <= {shadow[119:0], data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      idx         <= '0;
      sum         <= '0;
      cnt_clk     <= '0;
      cnt_square  <= '0;
      cnt_pulse   <= '0;
      cnt_time    <= '0;
      frame_valid <= 1'b0;
      chk_err     <= 1'b0;
      frm_err     <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      chk_err     <= 1'b0;
      frm_err     <= 1'b0;
      unique case (state)
        HUNT: begin
          // Line errors here are just noise before a frame; ignore them.
          if (byte_valid && data == HEADER) begin
            state <= PAYLOAD;
            idx   <= '0;
            sum   <= '0;
          end
        end
        PAYLOAD, CHECK: begin
          if (byte_err || (timeout && !byte_valid)) begin
            frm_err <= 1'b1;
            state   <= HUNT;
          end else if (byte_valid) begin
            if (state == PAYLOAD) begin
              // A header value here is payload data, never a resync.
              sum <= sum + data;
              idx <= idx + 4'd1;
              if (idx == 4'(PAYLOAD_LEN - 1)) state <= CHECK;
            end else begin
              if (data == sum) begin
                cnt_clk     <= shadow[127:96];
                cnt_square  <= shadow[95:64];
                cnt_pulse   <= shadow[63:32];
                cnt_time    <= shadow[31:0];
                frame_valid <= 1'b1;
              end else begin
                chk_err <= 1'b1;
              end
              state <= HUNT;
            end
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed self-checking bench for uart_rx_frame. Runs at a reduced
// divider (20 clocks per bit) so the complete sequence stays short.
module tb_uart_rx_frame;
  import uart_frame_pkg::*;

  localparam int CLK_FREQ     = 2_000_000;
  localparam int BAUD         = 100_000;
  localparam int BAUD_DIV     = CLK_FREQ / BAUD;
  localparam int TIMEOUT_BITS = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;
  logic [31:0] cnt_clk, cnt_square, cnt_pulse, cnt_time;
  logic        frame_valid, chk_err, frm_err;
  logic [127:0] outs;

  assign outs = {cnt_clk, cnt_square, cnt_pulse, cnt_time};

  always #5 clk = ~clk;

  uart_rx_frame #(
    .CLK_FREQ     (CLK_FREQ),
    .BAUD         (BAUD),
    .HEADER       (8'hA5),
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .cnt_clk     (cnt_clk),
    .cnt_square  (cnt_square),
    .cnt_pulse   (cnt_pulse),
    .cnt_time    (cnt_time),
    .frame_valid (frame_valid),
    .chk_err     (chk_err),
    .frm_err     (frm_err)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Event monitor, sampled on the inactive edge.
  int           cyc = 0;
  int           bv_n = 0, fv_n = 0, chk_n = 0, frm_n = 0;
  int           bv_cyc = 0, fv_cyc = 0, frm_cyc = 0;
  int           excl_n = 0, upd_n = 0;
  logic [127:0] prev_outs = '0;

  always @(negedge clk) begin
    cyc++;
    if (u_dut.byte_valid) begin bv_n++; bv_cyc = cyc; end
    if (frame_valid)      begin fv_n++; fv_cyc = cyc; end
    if (chk_err)          chk_n++;
    if (frm_err)          begin frm_n++; frm_cyc = cyc; end
    if (int'(frame_valid) + int'(chk_err) + int'(frm_err) > 1) excl_n++;
    if (rst_n === 1'b1 && !frame_valid && outs !== prev_outs) upd_n++;
    prev_outs = outs;
  end

  int bv0, fv0, chk0, frm0;

  task automatic snap();
    bv0  = bv_n;
    fv0  = fv_n;
    chk0 = chk_n;
    frm0 = frm_n;
  endtask

  logic [7:0] fb [FRAME_LEN];

  // Builds header + big-endian counters + mod-256 sum of the 16 payload bytes.
  task automatic load_frame(input logic [31:0] a, b, c, d);
    logic [127:0] p;
    logic [7:0]   s;
    p = {a, b, c, d};
    s = 8'h00;
    fb[0] = 8'hA5;
    for (int i = 0; i < PAYLOAD_LEN; i++) begin
      fb[i+1] = p[127-8*i -: 8];
      s = s + fb[i+1];
    end
    fb[FRAME_LEN-1] = s;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rx = 1'b0;
    repeat (BAUD_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BAUD_DIV) @(negedge clk);
    end
    rx = bad_stop ? 1'b0 : 1'b1;
    repeat (BAUD_DIV) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_bytes(input int first, input int last, input int bad_stop_at);
    for (int i = first; i <= last; i++) send_byte(fb[i], i == bad_stop_at);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BAUD_DIV) @(negedge clk);
  endtask

  localparam logic [127:0] F1 = {32'h05F5E100, 32'h00000064, 32'h00000032, 32'h12345678};
  localparam logic [127:0] F2 = {32'h00000001, 32'h00000002, 32'h00000003, 32'hA5A5A5A5};
  localparam logic [127:0] F3 = {32'hDEADBEEF, 32'h0000FFFF, 32'h80000001, 32'h00C0FFEE};

  initial begin
    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_outputs", outs, '0);
    check("reset_strobes", {frame_valid, chk_err, frm_err}, 3'b000);
    rst_n = 1'b1;
    idle_bits(2);

    // Bad checksum: dropped, outputs stay at reset values.
    load_frame(F1[127:96], F1[95:64], F1[63:32], F1[31:0]);
    fb[FRAME_LEN-1] = fb[FRAME_LEN-1] + 8'd1;
    snap();
    send_bytes(0, FRAME_LEN - 1, -1);
    idle_bits(3);
    check("badsum_chk_err", chk_n - chk0, 1);
    check("badsum_no_fv", fv_n - fv0, 0);
    check("badsum_no_frm", frm_n - frm0, 0);
    check("badsum_outs_hold", outs, '0);

    // Good frame.
    load_frame(F1[127:96], F1[95:64], F1[63:32], F1[31:0]);
    snap();
    send_bytes(0, FRAME_LEN - 1, -1);
    idle_bits(3);
    check("good_fv_once", fv_n - fv0, 1);
    check("good_fv_latency", fv_cyc - bv_cyc, 1);
    check("good_no_err", (chk_n - chk0) + (frm_n - frm0), 0);
    check("good_cnt_clk", cnt_clk, 32'h05F5E100);
    check("good_cnt_square", cnt_square, 32'h00000064);
    check("good_cnt_pulse", cnt_pulse, 32'h00000032);
    check("good_cnt_time", cnt_time, 32'h12345678);

    // Garbage before header, header value embedded in payload.
    load_frame(F2[127:96], F2[95:64], F2[63:32], F2[31:0]);
    snap();
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h5A, 1'b0);
    send_bytes(0, FRAME_LEN - 1, -1);
    idle_bits(3);
    check("garbage_fv_once", fv_n - fv0, 1);
    check("garbage_no_err", (chk_n - chk0) + (frm_n - frm0), 0);
    check("garbage_outs", outs, F2);

    // Stop bit low on payload byte 7, then a full good frame.
    load_frame(F1[127:96], F1[95:64], F1[63:32], F1[31:0]);
    snap();
    send_bytes(0, 8, 8);
    idle_bits(2);
    check("stoperr_frm_err", frm_n - frm0, 1);
    check("stoperr_no_fv", fv_n - fv0, 0);
    check("stoperr_outs_hold", outs, F2);
    snap();
    send_bytes(0, FRAME_LEN - 1, -1);
    idle_bits(3);
    check("after_stoperr_fv", fv_n - fv0, 1);
    check("after_stoperr_outs", outs, F1);

    // Idle after payload byte 9 until the inter-byte timeout fires.
    load_frame(F3[127:96], F3[95:64], F3[63:32], F3[31:0]);
    snap();
    send_bytes(0, 10, -1);
    idle_bits(25);
    check("timeout_frm_err", frm_n - frm0, 1);
    check("timeout_delay", frm_cyc - bv_cyc, TIMEOUT_BITS * BAUD_DIV);
    check("timeout_no_fv", fv_n - fv0, 0);
    check("timeout_outs_hold", outs, F1);

    // Reset pulse in the middle of payload byte 12; the remainder of that
    // frame must never be accepted.
    snap();
    send_bytes(0, 12, -1);
    fork
      send_bytes(13, FRAME_LEN - 1, -1);
      begin
        repeat (4 * BAUD_DIV) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset_outs", outs, '0);
        check("midreset_strobes", {frame_valid, chk_err, frm_err}, 3'b000);
        rst_n = 1'b1;
      end
    join
    idle_bits(30);
    check("postreset_no_fv", fv_n - fv0, 0);
    check("postreset_outs", outs, '0);
    send_bytes(0, FRAME_LEN - 1, -1);
    idle_bits(3);
    check("postreset_fv_once", fv_n - fv0, 1);
    check("postreset_outs_new", outs, F3);

    // 0.4-bit low glitch on the idle line.
    snap();
    rx = 1'b0;
    repeat (BAUD_DIV * 2 / 5) @(negedge clk);
    rx = 1'b1;
    idle_bits(3);
    check("glitch_no_byte", bv_n - bv0, 0);
    check("glitch_no_strobe", (fv_n - fv0) + (chk_n - chk0) + (frm_n - frm0), 0);
    check("glitch_outs_hold", outs, F3);

    check("strobes_exclusive", excl_n, 0);
    check("no_partial_update", upd_n, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
